// File: rtl/datapath_lane_seq_if.sv
// ============================================================================
// Module      : datapath_lane_seq_if
// Description : Control/status bundle between byte-packing control and the
//               datapath lane sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface datapath_lane_seq_if #(
    parameter int SEL_W = 2
);
    logic                  CLR;
    logic                  LOAD;
    logic [SEL_W-1:0]      LOAD_SEL;
    logic [SEL_W-1:0]      LAST_SEL;
    logic                  ADV;
    logic                  DIR;
    logic                  STOP_AT_TC;
    logic                  EN;
    logic [(2**SEL_W)-1:0] D;
    logic [SEL_W-1:0]      SEL;
    logic                  TC;
    logic                  BUSY;

    modport master (
        output CLR, LOAD, LOAD_SEL, LAST_SEL, ADV, DIR, STOP_AT_TC, EN,
        input  D, SEL, TC, BUSY
    );

    modport slave (
        input  CLR, LOAD, LOAD_SEL, LAST_SEL, ADV, DIR, STOP_AT_TC, EN,
        output D, SEL, TC, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/datapath_lane_seq.sv
// ============================================================================
// Module      : datapath_lane_seq
// Description : Registered lane pointer with one-hot EN-gated lane enables and
//               a terminal-count pulse. Optional saturate-at-last behaviour is
//               enabled by defining DATAPATH_LANE_SEQ_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module datapath_lane_seq #(
    parameter int SEL_W    = 2,
    parameter int LAST_DEF = (2**SEL_W) - 1
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    datapath_lane_seq_if.slave lane
);

    localparam int              LANES    = 2**SEL_W;
    localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(LAST_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] start_q;
    logic [SEL_W-1:0] last_q;
    logic             tc_q;
    logic             busy_q;

    // Pointer step wraps naturally at the SEL_W-bit boundary.
    logic [SEL_W-1:0] step_d;
    assign step_d = lane.DIR ? (sel_q - SEL_W'(1)) : (sel_q + SEL_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            start_q <= '0;
            last_q  <= LAST_RST;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (lane.CLR) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (lane.LOAD) begin
                // Reload drops any coincident ADV, so no TC here.
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
                sel_q   <= lane.LOAD_SEL;
                start_q <= lane.LOAD_SEL;
                last_q  <= lane.LAST_SEL;
            end else if (state_q == ST_RUN && lane.ADV) begin
                if (sel_q == last_q) begin
                    tc_q <= 1'b1;
                    if (lane.STOP_AT_TC) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
`ifdef DATAPATH_LANE_SEQ_SATURATE_EN
                        state_q <= ST_HOLD;
`else
                        sel_q   <= start_q;
`endif
                    end
                end else begin
                    sel_q <= step_d;
                end
            end
        end
    end

    assign lane.SEL  = sel_q;
    assign lane.TC   = tc_q;
    assign lane.BUSY = busy_q;
    assign lane.D    = (busy_q && lane.EN) ? (LANES'(1) << sel_q) : '0;

endmodule

`default_nettype wire

// File: tb/tb_datapath_lane_seq.sv
// ============================================================================
// Module      : tb_datapath_lane_seq
// Description : Scoreboard bench for datapath_lane_seq: directed sequences plus
//               randomized traffic against a behavioural lane-sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_datapath_lane_seq;

    localparam int SEL_W = 2;
    localparam int LANES = 2**SEL_W;

    typedef struct {
        int sel;
        int d;
        int tc;
        int busy;
    } exp_t;

    logic CLK;
    logic RST;
    datapath_lane_seq_if #(.SEL_W(SEL_W)) bus ();

    datapath_lane_seq #(.SEL_W(SEL_W)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .lane (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    // Reference model state: the sequence as a list of lanes walked from start.
    bit m_busy, m_hold;
    int m_sel, m_start, m_last, m_tc;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_d(input bit en);
        if (m_busy && en) return 1 << m_sel;
        return 0;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_hold = 0; m_sel = 0; m_start = 0; m_last = LANES - 1; m_tc = 0;
    endfunction

    function automatic void model_step(input bit clr, input bit load, input int lsel,
                                       input int lastsel, input bit adv, input bit dir,
                                       input bit stop);
        m_tc = 0;
        if (clr) begin
            m_busy = 0; m_hold = 0;
        end else if (load) begin
            m_sel = lsel; m_start = lsel; m_last = lastsel; m_busy = 1; m_hold = 0;
        end else if (m_busy && !m_hold && adv) begin
            if (m_sel == m_last) begin
                m_tc = 1;
                if (stop) begin
                    m_busy = 0; m_hold = 0;
                end else begin
`ifdef DATAPATH_LANE_SEQ_SATURATE_EN
                    m_hold = 1;
`else
                    m_sel = m_start;
`endif
                end
            end else if (dir) begin
                m_sel = (m_sel + LANES - 1) % LANES;
            end else begin
                m_sel = (m_sel + 1) % LANES;
            end
        end
    endfunction

    task automatic push_exp(input bit en);
        exp_t e;
        e.sel = m_sel; e.d = model_d(en); e.tc = m_tc; e.busy = int'(m_busy);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit clr, input bit load, input int lsel, input int lastsel,
                       input bit adv, input bit dir, input bit stop, input bit en);
        @(negedge CLK);
        RST            = 1'b0;
        bus.CLR        = clr;
        bus.LOAD       = load;
        bus.LOAD_SEL   = SEL_W'(lsel);
        bus.LAST_SEL   = SEL_W'(lastsel);
        bus.ADV        = adv;
        bus.DIR        = dir;
        bus.STOP_AT_TC = stop;
        bus.EN         = en;
        model_step(clr, load, lsel, lastsel, adv, dir, stop);
        push_exp(en);
    endtask

    // Async reset asserted mid-cycle; outputs must clear before any edge.
    task automatic rst_mid(input bit en);
        @(negedge CLK);
        bus.CLR = 1'b0; bus.LOAD = 1'b0; bus.ADV = 1'b0; bus.EN = en;
        RST = 1'b1;
        #1;
        chk("rst_D",    int'(bus.D),    0);
        chk("rst_SEL",  int'(bus.SEL),  0);
        chk("rst_BUSY", int'(bus.BUSY), 0);
        chk("rst_TC",   int'(bus.TC),   0);
        model_reset();
        push_exp(en);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("SEL",  int'(bus.SEL),  e.sel);
                chk("D",    int'(bus.D),    e.d);
                chk("TC",   int'(bus.TC),   e.tc);
                chk("BUSY", int'(bus.BUSY), e.busy);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        bit ld, same;
        int r, ls;
        RST = 1'b0;
        bus.CLR = 0; bus.LOAD = 0; bus.LOAD_SEL = '0; bus.LAST_SEL = '0;
        bus.ADV = 0; bus.DIR = 0; bus.STOP_AT_TC = 0; bus.EN = 1;
        model_reset();

        // Plan 1: forward walk 0..3, stop at terminal lane.
        rst_mid(1'b1);
        cyc(0, 1, 0, 3, 0, 0, 1, 1);
        repeat (4) cyc(0, 0, 0, 0, 1, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 1);

        // Plan 2: wrap through lane 0 back to start.
        cyc(0, 1, 2, 1, 0, 0, 0, 1);
        repeat (5) cyc(0, 0, 0, 0, 1, 0, 0, 1);

        // Plan 3: decrement 0 -> 3 -> 2 then stop.
        cyc(0, 1, 0, 2, 0, 1, 1, 1);
        repeat (3) cyc(0, 0, 0, 0, 1, 1, 1, 1);

        // Plan 4: EN is a zero-latency gate on D.
        cyc(0, 1, 0, 3, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("en_on_D", int'(bus.D), 2);
        bus.EN = 1'b0;
        #1;
        chk("en_off_D", int'(bus.D), 0);
        chk("en_off_SEL", int'(bus.SEL), 1);
        bus.EN = 1'b1;
        #1;
        chk("en_back_D", int'(bus.D), 2);
        cyc(1, 0, 0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0, 1, 1);

        // Plan 5: LOAD beats ADV at the terminal lane, then async reset.
        cyc(0, 1, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 0, 0, 1);
        cyc(0, 1, 3, 3, 1, 0, 0, 1);
        rst_mid(1'b1);

        // Plan 6: saturate (when compiled) or wrap, then CLR.
        cyc(0, 1, 0, 3, 0, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 0, 1, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        // Single-lane sequence with ADV held: TC every cycle.
        cyc(0, 1, 2, 2, 0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 0, 1, 1, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst_mid(1'($urandom_range(0, 1)));
            end else begin
                ld   = ($urandom_range(0, 99) < 15);
                same = ($urandom_range(0, 3) == 0);
                ls   = $urandom_range(0, LANES - 1);
                cyc(r < 6, ld, ls, same ? ls : $urandom_range(0, LANES - 1),
                    $urandom_range(0, 99) < 65, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8);
            end
        end

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge CLK);
        #2;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
